clken_nco_bank: RTL

Multi-channel clock-enable generator for the `refclk` domain: a bank of per-channel phase accumulators (NCOs) that emit single-cycle enable strobes at programmable, fractionally exact rates relative to `refclk`. It is the parametrised successor to the fixed-output PLL wrapper. The PLL produces the fabric clock; this block derives N run-time-programmable rates from it, with phase control, group phase alignment and a `locked` indication. It sits directly behind the PLL, and its strobes gate downstream logic in the same clock domain.

---
 rtl/clken_nco_bank.sv | 136 +++++++++++++
 1 files changed

// File: rtl/clken_nco_bank.sv
// Bank of NCH phase-accumulator clock-enable generators with group sync and lock indication.
// Optional macro CLKEN_NCO_SQUARE_EN adds a per-channel square-wave output `sq`.
module clken_nco_bank #(
  parameter int NCH      = 2,
  parameter int ACC_W    = 24,
  parameter int LOCK_CYC = 16,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             cfg_wr,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic [ACC_W-1:0] cfg_phase,
  input  logic             sync,
  output logic [NCH-1:0]   en,
`ifdef CLKEN_NCO_SQUARE_EN
  output logic [NCH-1:0]   sq,
`endif
  output logic             locked
);

  localparam int CNT_W = $clog2(LOCK_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

  logic [NCH-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [NCH-1:0][ACC_W-1:0] inc_q, inc_d;
  logic [NCH-1:0][ACC_W-1:0] phase_q, phase_d;
  logic [NCH-1:0][ACC_W:0]   sum;
  logic [NCH-1:0]            en_q, en_d;
  logic [NCH-1:0]            load_sel;
  logic                      wr_valid;
  logic                      any_nz;
  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      locked_q, locked_d;

  // Channel decode by equality so out-of-range cfg_ch values simply match nothing.
  always_comb begin
    load_sel = '0;
    wr_valid = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (cfg_wr && (cfg_ch == CH_W'(c))) begin
        load_sel[c] = 1'b1;
        wr_valid    = 1'b1;
      end
    end
  end

  always_comb begin
    acc_d   = acc_q;
    inc_d   = inc_q;
    phase_d = phase_q;
    en_d    = '0;
    sum     = '0;
    any_nz  = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      sum[c] = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
      if (load_sel[c]) begin
        inc_d[c]   = cfg_inc;
        phase_d[c] = cfg_phase;
        acc_d[c]   = cfg_phase;
      end else if (sync) begin
        acc_d[c]   = phase_q[c];
      end else begin
        acc_d[c]   = sum[c][ACC_W-1:0];
        en_d[c]    = sum[c][ACC_W];
      end
      if (inc_d[c] != '0) any_nz = 1'b1;
    end
  end

  // Lock FSM judges "all disabled" on the post-write increments.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (wr_valid || sync) begin
      cnt_d   = '0;
      state_d = any_nz ? SETTLE : IDLE;
    end else begin
      case (state_q)
        SETTLE: begin
          if (cnt_q == CNT_W'(LOCK_CYC)) state_d = LOCKED;
          else                           cnt_d   = cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      inc_q    <= '0;
      phase_q  <= '0;
      en_q     <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      inc_q    <= inc_d;
      phase_q  <= phase_d;
      en_q     <= en_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign en     = en_q;
  assign locked = locked_q;

`ifdef CLKEN_NCO_SQUARE_EN
  logic [NCH-1:0] sq_q, sq_d;

  always_comb begin
    sq_d = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      sq_d[c] = (inc_d[c] != '0) & acc_d[c][ACC_W-1];
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sq_q <= '0;
    else        sq_q <= sq_d;
  end

  assign sq = sq_q;
`else
  // Square-wave outputs are not built in this configuration.
`endif

endmodule
